// File: rtl/hud_pkg.sv
// Shared HUD definitions: glyph geometry, seven-segment masks,
// the digit-to-segment table and the default HUD colours.
package hud_pkg;

    localparam int GLYPH_W      = 10;
    localparam int GLYPH_H      = 10;
    localparam int GLYPH_PIXELS = GLYPH_W * GLYPH_H;

    localparam int               HUD_COLOR_BITS = 12;
    localparam logic [11:0]      HUD_FG_COLOR   = 12'hFFF;
    localparam logic [11:0]      HUD_BG_COLOR   = 12'h000;

    // One bit per segment, bit order {g,f,e,d,c,b,a}
    typedef logic [6:0] seg_mask_t;

    localparam seg_mask_t SEG_A = 7'b000_0001;
    localparam seg_mask_t SEG_B = 7'b000_0010;
    localparam seg_mask_t SEG_C = 7'b000_0100;
    localparam seg_mask_t SEG_D = 7'b000_1000;
    localparam seg_mask_t SEG_E = 7'b001_0000;
    localparam seg_mask_t SEG_F = 7'b010_0000;
    localparam seg_mask_t SEG_G = 7'b100_0000;

    localparam seg_mask_t DIGIT_SEGS [10] = '{
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F,          // 0
        SEG_B | SEG_C,                                          // 1
        SEG_A | SEG_B | SEG_D | SEG_E | SEG_G,                  // 2
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_G,                  // 3
        SEG_B | SEG_C | SEG_F | SEG_G,                          // 4
        SEG_A | SEG_C | SEG_D | SEG_F | SEG_G,                  // 5
        SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,          // 6
        SEG_A | SEG_B | SEG_C,                                  // 7
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,  // 8
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G           // 9
    };

    // First pipeline stage payload: selected digit cell pixel
    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
        logic [7:0] index;
    } stage1_t;

    // Segments lit for a digit value; values 10..15 render blank
    function automatic seg_mask_t digit_segments(input logic [3:0] digit);
        if (digit < 4'd10) begin
            return DIGIT_SEGS[digit];
        end
        return '0;
    endfunction

endpackage

// File: rtl/digit_pixel_renderer_if.sv
// Bus between the HUD time/score controllers and the pixel renderer.
interface digit_pixel_renderer_if #(
    parameter int COLOR_BITS = 12
);
    logic                  en_time;
    logic [3:0]            selected_time_number;
    logic [7:0]            time_count;
    logic                  en_score;
    logic [3:0]            selected_score_number;
    logic [7:0]            score_count;
    logic                  pixel_valid;
    logic                  pixel_on;
    logic [COLOR_BITS-1:0] rgb;
    logic                  overlap_err;

    modport master (
        output en_time, selected_time_number, time_count,
        output en_score, selected_score_number, score_count,
        input  pixel_valid, pixel_on, rgb, overlap_err
    );

    modport slave (
        input  en_time, selected_time_number, time_count,
        input  en_score, selected_score_number, score_count,
        output pixel_valid, pixel_on, rgb, overlap_err
    );
endinterface

// File: rtl/digit_glyph_rom.sv
// Combinational 10x10 seven-segment glyph: (digit, pixel index) -> lit bit.
// The index is split into row/col with a threshold compare chain rather
// than a divider, then each pixel is mapped to the segment it belongs to.
module digit_glyph_rom
    import hud_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [7:0] index,
    output logic       pixel_bit
);

    logic [3:0] row;
    logic [3:0] col;
    logic       in_range;
    logic       mid_col;
    logic       upper_rows;
    logic       lower_rows;
    seg_mask_t  pixel_segs;

    // Decode index into row/col and find which segment covers this pixel
    always_comb begin
        row = '0;
        for (int r = 1; r < GLYPH_H; r++) begin
            if (index >= 8'(r * GLYPH_W)) begin
                row = 4'(r);
            end
        end
        col        = 4'(index - 8'(int'(row) * GLYPH_W));
        in_range   = (index < 8'(GLYPH_PIXELS));
        mid_col    = (col >= 4'd1) && (col <= 4'(GLYPH_W - 2));
        upper_rows = (row >= 4'd1) && (row <= 4'd3);
        lower_rows = (row >= 4'd5) && (row <= 4'(GLYPH_H - 2));

        pixel_segs = '0;
        if (row == 4'd0 && mid_col)                    pixel_segs = SEG_A;
        if (row == 4'd4 && mid_col)                    pixel_segs = SEG_G;
        if (row == 4'(GLYPH_H - 1) && mid_col)         pixel_segs = SEG_D;
        if (col == 4'(GLYPH_W - 1) && upper_rows)      pixel_segs = SEG_B;
        if (col == 4'(GLYPH_W - 1) && lower_rows)      pixel_segs = SEG_C;
        if (col == 4'd0 && upper_rows)                 pixel_segs = SEG_F;
        if (col == 4'd0 && lower_rows)                 pixel_segs = SEG_E;

        pixel_bit = in_range && |(pixel_segs & digit_segments(digit));
    end

endmodule

// File: rtl/digit_pixel_renderer.sv
// HUD digit renderer: selects the active time/score digit cell, looks up
// the glyph pixel and produces a registered colour two clocks later.
module digit_pixel_renderer
    import hud_pkg::*;
#(
    parameter int                    COLOR_BITS = HUD_COLOR_BITS,
    parameter logic [COLOR_BITS-1:0] FG_COLOR   = COLOR_BITS'(HUD_FG_COLOR),
    parameter logic [COLOR_BITS-1:0] BG_COLOR   = COLOR_BITS'(HUD_BG_COLOR)
) (
    input  logic                    clock_25,
    input  logic                    reset,
    input  logic                    sync_reset,
    digit_pixel_renderer_if.slave   hud
);

    stage1_t               stage1_d;
    stage1_t               stage1_q;
    logic                  glyph_bit;
    logic                  pixel_valid_q;
    logic                  pixel_on_q;
    logic [COLOR_BITS-1:0] rgb_q;
    logic                  overlap_q;

    digit_glyph_rom u_glyph_rom (
        .digit     (stage1_q.digit),
        .index     (stage1_q.index),
        .pixel_bit (glyph_bit)
    );

    // Source select: time cell has priority over score cell
    always_comb begin
        stage1_d = '0;
        if (hud.en_time) begin
            stage1_d.valid = 1'b1;
            stage1_d.digit = hud.selected_time_number;
            stage1_d.index = hud.time_count;
        end else if (hud.en_score) begin
            stage1_d.valid = 1'b1;
            stage1_d.digit = hud.selected_score_number;
            stage1_d.index = hud.score_count;
        end
    end

    // Stage 1 register plus the sticky overlap flag
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            stage1_q  <= '0;
            overlap_q <= 1'b0;
        end else if (sync_reset) begin
            stage1_q  <= '0;
            overlap_q <= 1'b0;
        end else begin
            stage1_q  <= stage1_d;
            overlap_q <= overlap_q | (hud.en_time & hud.en_score);
        end
    end

    // Stage 2: glyph bit to registered pixel flags and colour
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            pixel_valid_q <= 1'b0;
            pixel_on_q    <= 1'b0;
            rgb_q         <= '0;
        end else if (sync_reset) begin
            pixel_valid_q <= 1'b0;
            pixel_on_q    <= 1'b0;
            rgb_q         <= '0;
        end else begin
            pixel_valid_q <= stage1_q.valid;
            pixel_on_q    <= stage1_q.valid & glyph_bit;
            if (!stage1_q.valid) begin
                rgb_q <= '0;
            end else if (glyph_bit) begin
                rgb_q <= FG_COLOR;
            end else begin
                rgb_q <= BG_COLOR;
            end
        end
    end

    assign hud.pixel_valid = pixel_valid_q;
    assign hud.pixel_on    = pixel_on_q;
    assign hud.rgb         = rgb_q;
    assign hud.overlap_err = overlap_q;

endmodule

// File: tb/tb_digit_pixel_renderer.sv
// Self-checking bench for digit_pixel_renderer: a font-level reference
// model checked every cycle, directed literal cases, and random traffic.
module tb_digit_pixel_renderer;

    logic clock_25   = 1'b0;
    logic reset      = 1'b1;
    logic sync_reset = 1'b0;

    digit_pixel_renderer_if #(.COLOR_BITS(12)) hud_bus ();

    digit_pixel_renderer dut (
        .clock_25   (clock_25),
        .reset      (reset),
        .sync_reset (sync_reset),
        .hud        (hud_bus)
    );

    always #20 clock_25 = ~clock_25;

    int check_count = 0;
    int pass_count  = 0;
    bit compare_en  = 1'b0;

    // Reference font: segments named per digit, pixels named by segment
    string font_segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                              "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic bit model_bit(input int digit, input int index);
        int    row;
        int    col;
        string seg_name;
        string segs;
        if (index >= 100 || digit > 9) return 1'b0;
        row = index / 10;
        col = index % 10;
        seg_name = "";
        if (row == 0 && col >= 1 && col <= 8) seg_name = "a";
        if (row == 4 && col >= 1 && col <= 8) seg_name = "g";
        if (row == 9 && col >= 1 && col <= 8) seg_name = "d";
        if (col == 9 && row >= 1 && row <= 3) seg_name = "b";
        if (col == 9 && row >= 5 && row <= 8) seg_name = "c";
        if (col == 0 && row >= 1 && row <= 3) seg_name = "f";
        if (col == 0 && row >= 5 && row <= 8) seg_name = "e";
        if (seg_name == "") return 1'b0;
        segs = font_segs[digit];
        for (int k = 0; k < segs.len(); k++) begin
            if (segs.substr(k, k) == seg_name) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model state: pixel accepted last edge, and expected outputs
    bit        pend_valid   = 1'b0;
    int        pend_digit   = 0;
    int        pend_index   = 0;
    bit        exp_valid    = 1'b0;
    bit        exp_on       = 1'b0;
    bit [11:0] exp_rgb      = 12'h000;
    bit        exp_overlap  = 1'b0;

    // Advance the reference model on every clock edge or async reset
    always @(posedge clock_25 or negedge reset) begin
        if (!reset || sync_reset) begin
            pend_valid  = 1'b0;
            exp_valid   = 1'b0;
            exp_on      = 1'b0;
            exp_rgb     = 12'h000;
            exp_overlap = 1'b0;
        end else begin
            exp_valid = pend_valid;
            exp_on    = pend_valid && model_bit(pend_digit, pend_index);
            exp_rgb   = !pend_valid ? 12'h000 : (exp_on ? 12'hFFF : 12'h000);
            if (hud_bus.en_time && hud_bus.en_score) exp_overlap = 1'b1;
            pend_valid = hud_bus.en_time || hud_bus.en_score;
            pend_digit = hud_bus.en_time ? int'(hud_bus.selected_time_number)
                                         : int'(hud_bus.selected_score_number);
            pend_index = hud_bus.en_time ? int'(hud_bus.time_count)
                                         : int'(hud_bus.score_count);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Compare DUT against the model on every falling edge
    always @(negedge clock_25) begin
        if (compare_en) begin
            check_output("model_valid",   32'(hud_bus.pixel_valid), 32'(exp_valid));
            check_output("model_on",      32'(hud_bus.pixel_on),    32'(exp_on));
            check_output("model_rgb",     32'(hud_bus.rgb),         32'(exp_rgb));
            check_output("model_overlap", 32'(hud_bus.overlap_err), 32'(exp_overlap));
        end
    end

    task automatic apply_stimulus(input bit et, input int td, input int ti,
                                  input bit es, input int sd, input int si);
        hud_bus.en_time               = et;
        hud_bus.selected_time_number  = 4'(td);
        hud_bus.time_count            = 8'(ti);
        hud_bus.en_score              = es;
        hud_bus.selected_score_number = 4'(sd);
        hud_bus.score_count           = 8'(si);
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    // Issue one time-cell pixel and check the literal result 2 clocks later
    task automatic check_directed(input string name, input int digit, input int index,
                                  input bit exp_v, input bit exp_o, input int exp_c);
        @(negedge clock_25);
        apply_stimulus(1'b1, digit, index, 1'b0, 0, 0);
        @(negedge clock_25);
        apply_idle();
        @(negedge clock_25);
        check_output({name, "_valid"}, 32'(hud_bus.pixel_valid), 32'(exp_v));
        check_output({name, "_on"},    32'(hud_bus.pixel_on),    32'(exp_o));
        check_output({name, "_rgb"},   32'(hud_bus.rgb),         32'(exp_c));
    endtask

    int valid_seen;

    initial begin
        apply_idle();
        #1 reset = 1'b0;
        repeat (2) @(negedge clock_25);
        check_output("reset_valid",   32'(hud_bus.pixel_valid), 32'd0);
        check_output("reset_on",      32'(hud_bus.pixel_on),    32'd0);
        check_output("reset_rgb",     32'(hud_bus.rgb),         32'd0);
        check_output("reset_overlap", 32'(hud_bus.overlap_err), 32'd0);
        reset = 1'b1;
        compare_en = 1'b1;

        check_directed("d8_i1",    8,   1, 1'b1, 1'b1, 12'hFFF);
        check_directed("d8_i0",    8,   0, 1'b1, 1'b0, 12'h000);
        check_directed("d0_i45",   0,  45, 1'b1, 1'b0, 12'h000);
        check_directed("d8_i45",   8,  45, 1'b1, 1'b1, 12'hFFF);
        check_directed("d1_i9",    1,   9, 1'b1, 1'b0, 12'h000);
        check_directed("d1_i19",   1,  19, 1'b1, 1'b1, 12'hFFF);
        check_directed("d1_i91",   1,  91, 1'b1, 1'b0, 12'h000);
        check_directed("d12_i19", 12,  19, 1'b1, 1'b0, 12'h000);
        check_directed("d8_i100",  8, 100, 1'b1, 1'b0, 12'h000);
        check_directed("d8_i255",  8, 255, 1'b1, 1'b0, 12'h000);

        // Back-to-back stream of digit 4 from the score cell
        valid_seen = 0;
        for (int i = 0; i < 102; i++) begin
            @(negedge clock_25);
            if (i >= 2 && hud_bus.pixel_valid) valid_seen++;
            if (i < 100) apply_stimulus(1'b0, 0, 0, 1'b1, 4, i);
            else         apply_idle();
        end
        check_output("stream_valid_count", 32'(valid_seen), 32'd100);

        // Overlap: time digit 3 wins, flag sticks until sync_reset
        @(negedge clock_25);
        apply_stimulus(1'b1, 3, 1, 1'b1, 7, 0);
        @(negedge clock_25);
        apply_idle();
        @(negedge clock_25);
        check_output("overlap_on",  32'(hud_bus.pixel_on),    32'd1);
        check_output("overlap_err", 32'(hud_bus.overlap_err), 32'd1);
        repeat (5) @(negedge clock_25);
        check_output("overlap_sticky", 32'(hud_bus.overlap_err), 32'd1);
        sync_reset = 1'b1;
        @(negedge clock_25);
        sync_reset = 1'b0;
        check_output("overlap_cleared", 32'(hud_bus.overlap_err), 32'd0);

        // In-flight pixel dropped by sync_reset
        @(negedge clock_25);
        apply_stimulus(1'b1, 8, 1, 1'b0, 0, 0);
        @(negedge clock_25);
        apply_idle();
        sync_reset = 1'b1;
        @(negedge clock_25);
        sync_reset = 1'b0;
        check_output("sync_drop_valid", 32'(hud_bus.pixel_valid), 32'd0);
        check_output("sync_drop_rgb",   32'(hud_bus.rgb),         32'd0);
        @(negedge clock_25);
        check_output("sync_drop_after", 32'(hud_bus.pixel_valid), 32'd0);

        // In-flight pixel dropped by an async reset pulse
        @(negedge clock_25);
        apply_stimulus(1'b1, 8, 1, 1'b0, 0, 0);
        @(negedge clock_25);
        apply_idle();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clock_25);
        check_output("areset_drop_valid", 32'(hud_bus.pixel_valid), 32'd0);
        check_output("areset_drop_on",    32'(hud_bus.pixel_on),    32'd0);
        check_output("areset_drop_rgb",   32'(hud_bus.rgb),         32'd0);

        // Random traffic checked by the model every cycle
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock_25);
            apply_stimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                       : $urandom_range(0, 99),
                           1'($urandom_range(0, 1)), $urandom_range(0, 15),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                       : $urandom_range(0, 99));
            sync_reset = ($urandom_range(0, 31) == 0);
        end
        @(negedge clock_25);
        apply_idle();
        sync_reset = 1'b0;
        repeat (3) @(negedge clock_25);
        compare_en = 1'b0;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
